pa_cp0_info_csr_param: RTL and testbench
========================================

# pa_cp0_info_csr_param

Parametrised machine-information CSR block for the CP0 register file. It supplies the mvendorid, marchid, mimpid and mhartid values, and an mcpuid window into a table of NUM_IDX 32-bit CPUID words. The window advances on each mcpuid read, or can be set by software writes. It sits beside the other CP0 CSR groups, is clocked by the gated register clock, and feeds the CSR read mux combinationally.

## Interface
Parameters:
- NUM_IDX, default 3: number of CPUID table entries, legal range 1..16.
- HARTID_W, default 4: width of the hart-ID strap, legal range 1..32.
- AUTO_INC, default 1: 1 = index advances on each mcpuid read; 0 = index changes only on writes.
- VENDOR_ID, default 32'h5B7: mvendorid constant.
- ARCH_ID, default 32'h0: marchid constant.
- IMP_ID, default 32'h0: mimpid constant.

Ports (clock and reset first):
- regs_clk  in  1  single block clock.
- cpurst_b  in  1  asynchronous, active-low reset.
- iui_regs_inst_csr  in  1  a CSR instruction retires this cycle.
- mcpuid_local_en  in  1  the CSR instruction reads mcpuid.
- mcpuid_wen  in  1  the CSR instruction writes mcpuid.
- iui_regs_wdata  in  32  CSR write data.
- pad_cpu_hartid  in  HARTID_W  hart-ID strap; quasi-static.
- cpuid_cfg_table  in  NUM_IDX*32  CPUID words, tied to constants at top level; entry i occupies bits [32i+31:32i].
- mcpuid_value  out  32  current CPUID word.
- mhartid_value  out  32  captured hart ID.
- mvendorid_value, marchid_value, mimpid_value  out  32 each  constants.
- cpuid_index  out  4  current index, for debug.
- cpuid_round_done  out  1  one-cycle pulse when a read wraps the index to 0.

## Operation
- rd_fire = iui_regs_inst_csr & mcpuid_local_en & AUTO_INC.
- wr_fire = iui_regs_inst_csr & mcpuid_wen.
- Index register, 4 bits, resets to 0. Update priority:
  1. wr_fire: index <= wdata[3:0] if wdata[3:0] < NUM_IDX, else 0.
  2. Otherwise rd_fire: index <= 0 if index == NUM_IDX-1, else index+1.
  3. Otherwise index holds.
- Simultaneous read and write (csrrw): the read returns the pre-write entry, and the write wins the update.
- mcpuid_value = {index[3:0], entry[index][27:0]}. Bits [31:28] always carry the index, overriding table bits [31:28].
- The index can never be >= NUM_IDX. Any out-of-range select still yields entry 0 (defensive default, no X).
- NUM_IDX == 1: index stays 0; every rd_fire pulses cpuid_round_done.
- cpuid_round_done is registered. It is 1 in the cycle after an rd_fire that moved the index from NUM_IDX-1 to 0 with no simultaneous wr_fire. Writes never pulse it.
- Hart-ID capture:
  - A hartid_vld flag and a HARTID_W capture register both reset to 0.
  - At the first regs_clk edge with cpurst_b high and hartid_vld == 0, capture pad_cpu_hartid and set hartid_vld. Later strap changes are ignored until the next reset.
  - mhartid_value = zero-extended capture register.
- mvendorid/marchid/mimpid are pure parameter constants, independent of reset.

## Timing
- Reset values: cpuid_index = 0, mcpuid_value = {4'h0, entry0[27:0]}, mhartid_value = 0, cpuid_round_done = 0, hartid_vld = 0.
- Read latency is 0: mcpuid_value reflects the index in the same cycle as the read. The index advance is visible from the next cycle.
- Back-to-back reads on consecutive cycles return consecutive entries with no bubble.
- The write effect is visible on mcpuid_value one cycle after wr_fire.
- Hart ID is valid from the 2nd regs_clk edge after cpurst_b rises (first edge captures). A read before capture returns 0.
- cpurst_b low mid-sequence immediately (asynchronously) forces the index to 0, drops the round_done pulse and clears hartid_vld. The strap is recaptured after release.
- mcpuid_local_en or mcpuid_wen without iui_regs_inst_csr has no effect.

## Test plan
- Defaults, table {A0000001, B0000002, C0000003}: reset, then 4 reads on consecutive cycles -> mcpuid_value 00000001, 10000002, 20000003, 00000001; cpuid_round_done high exactly once, in the cycle after the 3rd read.
- Write select: write wdata = 2 -> next cycle cpuid_index = 2, mcpuid_value[31:28] = 2. Write wdata = 7 (>= NUM_IDX) -> index 0. Neither write pulses round_done.
- csrrw at index 1, wdata = 0: read returns the index-1 word; next cycle index = 0 (write beats increment); no round_done.
- Hart ID: pad_cpu_hartid = 4'h5 at reset release -> mhartid_value = 0 for the first cycle, then 32'h5. Change the strap to 4'hA -> stays 5. Pulse reset -> recaptures 32'hA.
- Mid-sequence reset: advance to index 2, assert cpurst_b low between clock edges -> cpuid_index = 0 immediately, round_done = 0.
- Parameter sweep (NUM_IDX = 1, 16; AUTO_INC = 0): NUM_IDX = 1 -> every read pulses round_done and index stays 0. NUM_IDX = 16 -> the 16th read wraps to 0. AUTO_INC = 0 -> 5 reads leave the index unchanged.

Source files
------------

// File: rtl/pa_cp0_info_csr_param.sv
// pa_cp0_info_csr_param: machine-information CSRs with a read-advancing mcpuid window and hart-ID strap capture
module pa_cp0_info_csr_param #(
  parameter int          NUM_IDX   = 3,
  parameter int          HARTID_W  = 4,
  parameter int          AUTO_INC  = 1,
  parameter logic [31:0] VENDOR_ID = 32'h5B7,
  parameter logic [31:0] ARCH_ID   = 32'h0,
  parameter logic [31:0] IMP_ID    = 32'h0
)(
  input  logic                    regs_clk,
  input  logic                    cpurst_b,
  input  logic                    iui_regs_inst_csr,
  input  logic                    mcpuid_local_en,
  input  logic                    mcpuid_wen,
  input  logic [31:0]             iui_regs_wdata,
  input  logic [HARTID_W-1:0]     pad_cpu_hartid,
  input  logic [NUM_IDX*32-1:0]   cpuid_cfg_table,
  output logic [31:0]             mcpuid_value,
  output logic [31:0]             mhartid_value,
  output logic [31:0]             mvendorid_value,
  output logic [31:0]             marchid_value,
  output logic [31:0]             mimpid_value,
  output logic [3:0]              cpuid_index,
  output logic                    cpuid_round_done
);
  localparam logic [3:0] LAST = 4'(NUM_IDX - 1);
  localparam logic [4:0] NUM  = 5'(NUM_IDX);
  logic                r_hartid_vld;
  logic [HARTID_W-1:0] r_hartid;
  logic [3:0]          r_index;
  logic                r_round_done;
  logic                w_rd_fire;
  logic                w_wr_fire;
  logic [3:0]          w_wr_idx;
  logic [3:0]          w_inc_idx;
  logic [31:0]         w_tab [16];
  assign w_rd_fire = iui_regs_inst_csr & mcpuid_local_en & (AUTO_INC != 0);
  assign w_wr_fire = iui_regs_inst_csr & mcpuid_wen;
  assign w_wr_idx  = ({1'b0, iui_regs_wdata[3:0]} < NUM) ? iui_regs_wdata[3:0] : 4'd0;
  assign w_inc_idx = (r_index == LAST) ? 4'd0 : r_index + 4'd1;
  // Unused table slots alias entry 0 so any stray index still reads a defined word
  for (genvar g = 0; g < 16; g++) begin : g_tab
    if (g < NUM_IDX) begin : g_used
      assign w_tab[g] = cpuid_cfg_table[g*32 +: 32];
    end else begin : g_unused
      assign w_tab[g] = cpuid_cfg_table[31:0];
    end
  end
  assign mcpuid_value     = {r_index, w_tab[r_index][27:0]};
  assign mhartid_value    = 32'(r_hartid);
  assign mvendorid_value  = VENDOR_ID;
  assign marchid_value    = ARCH_ID;
  assign mimpid_value     = IMP_ID;
  assign cpuid_index      = r_index;
  assign cpuid_round_done = r_round_done;
  // Window index: a write selects directly and beats a concurrent read advance; wrap pulses round_done
  always_ff @(posedge regs_clk or negedge cpurst_b)
    if (!cpurst_b) begin
      r_index      <= 4'd0;
      r_round_done <= 1'b0;
    end else begin
      r_index      <= w_wr_fire ? w_wr_idx : w_rd_fire ? w_inc_idx : r_index;
      r_round_done <= w_rd_fire & ~w_wr_fire & (r_index == LAST);
    end
  // Latch the hart-ID strap once on the first clock after reset release
  always_ff @(posedge regs_clk or negedge cpurst_b)
    if (!cpurst_b) begin
      r_hartid_vld <= 1'b0;
      r_hartid     <= '0;
    end else if (!r_hartid_vld) begin
      r_hartid_vld <= 1'b1;
      r_hartid     <= pad_cpu_hartid;
    end
endmodule

// File: tb/tb_pa_cp0_info_csr_param.sv
// tb_pa_cp0_info_csr_param: scoreboard bench over default, NUM_IDX=1, NUM_IDX=16 and AUTO_INC=0 instances
module tb_pa_cp0_info_csr_param;
  logic clk = 1'b0, rst_n = 1'b0, inst = 1'b0, en = 1'b0, wen = 1'b0;
  logic [31:0] wd = '0;
  logic [3:0] pad = 4'h5;
  logic [95:0] t3 = {32'hC0000003, 32'hB0000002, 32'hA0000001};
  logic [31:0] t1 = 32'hF1234567;
  logic [511:0] t16;
  logic [31:0] mc [4], hid [4], ven [4], arc [4], imp [4];
  logic [3:0] ix [4];
  logic rdn [4];
  int tests = 0, fails = 0;
  int m_idx [4];
  logic m_rnd [4];
  int nn [4] = '{3, 1, 16, 3};
  int au [4] = '{1, 1, 1, 0};
  logic [3:0] m_hart;
  logic m_hv;
  typedef struct {string tag; int id; logic [31:0] val;} exp_t;
  exp_t q [$];
  always #5 clk = ~clk;
  pa_cp0_info_csr_param u0 (
    .regs_clk(clk), .cpurst_b(rst_n), .iui_regs_inst_csr(inst), .mcpuid_local_en(en), .mcpuid_wen(wen),
    .iui_regs_wdata(wd), .pad_cpu_hartid(pad), .cpuid_cfg_table(t3), .mcpuid_value(mc[0]), .mhartid_value(hid[0]),
    .mvendorid_value(ven[0]), .marchid_value(arc[0]), .mimpid_value(imp[0]), .cpuid_index(ix[0]), .cpuid_round_done(rdn[0]));
  pa_cp0_info_csr_param #(.NUM_IDX(1)) u1 (
    .regs_clk(clk), .cpurst_b(rst_n), .iui_regs_inst_csr(inst), .mcpuid_local_en(en), .mcpuid_wen(wen),
    .iui_regs_wdata(wd), .pad_cpu_hartid(pad), .cpuid_cfg_table(t1), .mcpuid_value(mc[1]), .mhartid_value(hid[1]),
    .mvendorid_value(ven[1]), .marchid_value(arc[1]), .mimpid_value(imp[1]), .cpuid_index(ix[1]), .cpuid_round_done(rdn[1]));
  pa_cp0_info_csr_param #(.NUM_IDX(16)) u2 (
    .regs_clk(clk), .cpurst_b(rst_n), .iui_regs_inst_csr(inst), .mcpuid_local_en(en), .mcpuid_wen(wen),
    .iui_regs_wdata(wd), .pad_cpu_hartid(pad), .cpuid_cfg_table(t16), .mcpuid_value(mc[2]), .mhartid_value(hid[2]),
    .mvendorid_value(ven[2]), .marchid_value(arc[2]), .mimpid_value(imp[2]), .cpuid_index(ix[2]), .cpuid_round_done(rdn[2]));
  pa_cp0_info_csr_param #(.AUTO_INC(0)) u3 (
    .regs_clk(clk), .cpurst_b(rst_n), .iui_regs_inst_csr(inst), .mcpuid_local_en(en), .mcpuid_wen(wen),
    .iui_regs_wdata(wd), .pad_cpu_hartid(pad), .cpuid_cfg_table(t3), .mcpuid_value(mc[3]), .mhartid_value(hid[3]),
    .mvendorid_value(ven[3]), .marchid_value(arc[3]), .mimpid_value(imp[3]), .cpuid_index(ix[3]), .cpuid_round_done(rdn[3]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ent(input int d, input int i);
    if (d == 1) return t1;
    if (d == 2) return t16[i*32 +: 32];
    return t3[i*32 +: 32];
  endfunction
  function automatic logic [31:0] obs(input int id);
    int d = id / 4;
    case (id % 4)
      0:       return mc[d];
      1:       return {28'd0, ix[d]};
      2:       return {31'd0, rdn[d]};
      default: return hid[d];
    endcase
  endfunction
  task automatic push(input string tag, input int id, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.id = id; e.val = v;
    q.push_back(e);
  endtask
  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      chk(e.tag, obs(e.id), e.val);
    end
  endtask
  task automatic push_cur();
    logic [31:0] e;
    logic [3:0] i;
    for (int d = 0; d < 4; d++) begin
      e = ent(d, m_idx[d]);
      i = 4'(m_idx[d]);
      push($sformatf("d%0d_mcpuid", d), d*4, {i, e[27:0]});
    end
  endtask
  task automatic push_state();
    for (int d = 0; d < 4; d++) begin
      push($sformatf("d%0d_index", d), d*4+1, 32'(m_idx[d]));
      push($sformatf("d%0d_round", d), d*4+2, {31'd0, m_rnd[d]});
    end
    push("d0_hartid", 3, m_hv ? {28'd0, m_hart} : 32'd0);
  endtask
  task automatic step(input logic ins, input logic rd, input logic wr, input logic [31:0] wdi);
    logic rf, wf;
    @(negedge clk);
    inst = ins; en = rd; wen = wr; wd = wdi;
    #1;
    push_cur();
    drain();
    for (int d = 0; d < 4; d++) begin
      rf = ins & rd & (au[d] != 0);
      wf = ins & wr;
      m_rnd[d] = rf & !wf & (m_idx[d] == nn[d] - 1);
      if (wf) m_idx[d] = (int'(wdi[3:0]) < nn[d]) ? int'(wdi[3:0]) : 0;
      else if (rf) m_idx[d] = (m_idx[d] == nn[d] - 1) ? 0 : m_idx[d] + 1;
    end
    if (!m_hv) begin
      m_hart = pad;
      m_hv = 1'b1;
    end
    @(posedge clk);
    #1;
    inst = 1'b0; en = 1'b0; wen = 1'b0;
    push_state();
    drain();
  endtask
  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      m_idx[d] = 0;
      m_rnd[d] = 1'b0;
    end
    m_hv = 1'b0;
    m_hart = 4'h0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    push_state();
    push_cur();
    drain();
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_state();
    drain();
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 16; i++) t16[i*32 +: 32] = 32'hDEADBEEF ^ (i * 32'h01010101);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    push_state();
    push_cur();
    drain();
    chk("vendorid", ven[0], 32'h5B7);
    chk("archid", arc[0], 32'h0);
    chk("impid", imp[0], 32'h0);
    rst_n = 1'b1;
    push_state();
    drain();
    repeat (4) step(1, 1, 0, 0);
    pad = 4'hA;
    step(1, 0, 1, 2);
    step(1, 0, 1, 7);
    step(0, 1, 1, 2);
    step(1, 0, 1, 1);
    step(1, 1, 1, 0);
    step(1, 0, 1, 2);
    do_reset();
    step(1, 0, 1, 2);
    step(1, 1, 0, 0);
    do_reset();
    repeat (17) step(1, 1, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
